// File: rtl/eq_gain_scheduler.sv
// eq_gain_scheduler
// Holds the six equalizer band gains (signed dB), applies UI steps and presets,
// tracks which bands changed, and streams one changed band per cycle to the
// DSP biquad chain while the DSP is between samples.
module eq_gain_scheduler #(
   parameter int GAIN_MAX  = 12,
   parameter int GAIN_MIN  = -12,
   parameter int FRAC_BITS = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [2:0]  i_band_sel,
   input  logic        i_up,
   input  logic        i_down,
   input  logic        i_preset_load,
   input  logic [1:0]  i_preset_id,
   input  logic        i_sample_start,
   input  logic        i_dsp_done,
   output logic [2:0]  o_set_gain,
   output logic [15:0] o_gain,
   output logic [4:0]  o_sel_gain,
   output logic        o_pending
);

   localparam int NB = 6;
   localparam logic signed [4:0] GMAX = 5'(GAIN_MAX);
   localparam logic signed [4:0] GMIN = 5'(GAIN_MIN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   // Preset gain for a band index 0..5 (band 1..6).
   function automatic logic signed [4:0] preset_gain(input logic [1:0] id, input int band);
      logic signed [4:0] r;
      r = '0;
      case (id)
         2'd1: case (band)
                  0: r = 5'sd6;
                  1: r = 5'sd4;
                  2: r = 5'sd2;
                  default: r = '0;
               endcase
         2'd2: case (band)
                  3: r = 5'sd2;
                  4: r = 5'sd4;
                  5: r = 5'sd6;
                  default: r = '0;
               endcase
         2'd3: case (band)
                  0: r = 5'sd6;
                  1: r = 5'sd3;
                  4: r = 5'sd3;
                  5: r = 5'sd6;
                  default: r = '0;
               endcase
         default: r = '0;
      endcase
      return r;
   endfunction

   logic signed [4:0] gain_all [NB];
   logic [NB-1:0]     dirty_set;
   logic [NB-1:0]     dirty_q, dirty_d, clr_vec;
   logic              busy_q, busy_d;
   state_t            state_q, state_d;
   logic [2:0]        set_gain_q, set_gain_d;
   logic [15:0]       gain_out_q, gain_out_d;
   logic              pending_q, pending_d;
   logic              write_ok, issue;
   logic              step_up, step_dn;
   logic [2:0]        lo_band;
   logic signed [4:0] lo_gain;
   logic [NB-1:0]     lo_oh;

   // Opposing step requests cancel; a preset overrides any step.
   assign step_up  = i_up & ~i_down & ~i_preset_load;
   assign step_dn  = i_down & ~i_up & ~i_preset_load;
   assign write_ok = ~busy_q & ~i_sample_start;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_band
         localparam logic [2:0] BAND = 3'(gi + 1);
         logic signed [4:0] gain_q, gain_d;
         logic              set_bit;

         // Next gain for this band; a saturated step leaves the band clean.
         always_comb begin
            gain_d  = gain_q;
            set_bit = 1'b0;
            if (i_preset_load) begin
               gain_d  = preset_gain(i_preset_id, gi);
               set_bit = 1'b1;
            end else if (i_band_sel == BAND) begin
               if (step_up && (gain_q < GMAX)) begin
                  gain_d  = gain_q + 5'sd1;
                  set_bit = 1'b1;
               end else if (step_dn && (gain_q > GMIN)) begin
                  gain_d  = gain_q - 5'sd1;
                  set_bit = 1'b1;
               end
            end
         end

         // Band gain register.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) gain_q <= '0;
            else       gain_q <= gain_d;
         end

         assign gain_all[gi]  = gain_q;
         assign dirty_set[gi] = set_bit;
      end
   endgenerate

   // Lowest-index dirty band and its current gain.
   always_comb begin
      lo_band = 3'd0;
      lo_gain = '0;
      lo_oh   = '0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (dirty_q[i]) begin
            lo_band  = 3'(i + 1);
            lo_gain  = gain_all[i];
            lo_oh    = '0;
            lo_oh[i] = 1'b1;
         end
      end
   end

   // Sequencer: a write is issued in any state as soon as a band is dirty and the
   // DSP is idle, so a request reaches the DSP two cycles after it is made.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|dirty_q) begin
               if (write_ok) issue   = 1'b1;
               else          state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!(|dirty_q))  state_d = S_IDLE;
            else if (write_ok) issue  = 1'b1;
         end
         S_ISSUE: begin
            if (!(|dirty_q))    state_d = S_IDLE;
            else if (!write_ok) state_d = S_WAIT;
            else                issue   = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // A new request to the band being written re-marks it (set beats clear).
      clr_vec = issue ? lo_oh : '0;
      dirty_d = (dirty_q & ~clr_vec) | dirty_set;
      if (issue) state_d = (|dirty_d) ? S_ISSUE : S_IDLE;

      set_gain_d = issue ? lo_band : 3'd0;
      gain_out_d = issue ? {{(11 - FRAC_BITS){lo_gain[4]}}, lo_gain, {FRAC_BITS{1'b0}}} : 16'd0;
      pending_d  = |dirty_d;
      busy_d     = i_sample_start ? 1'b1 : (i_dsp_done ? 1'b0 : busy_q);
   end

   // Control and output registers; reset forces a full resync of every band.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         dirty_q    <= {NB{1'b1}};
         busy_q     <= 1'b0;
         set_gain_q <= 3'd0;
         gain_out_q <= 16'd0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dirty_q    <= dirty_d;
         busy_q     <= busy_d;
         set_gain_q <= set_gain_d;
         gain_out_q <= gain_out_d;
         pending_q  <= pending_d;
      end
   end

   // Display gain of the selected band; invalid selections read as 0.
   always_comb begin
      o_sel_gain = 5'd0;
      for (int i = 0; i < NB; i++) begin
         if (i_band_sel == 3'(i + 1)) o_sel_gain = gain_all[i];
      end
   end

   assign o_set_gain = set_gain_q;
   assign o_gain     = gain_out_q;
   assign o_pending  = pending_q;

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Testbench for eq_gain_scheduler: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_eq_gain_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  band_sel;
   logic        up, down, pload;
   logic [1:0]  pid;
   logic        start, done;
   logic [2:0]  o_set_gain;
   logic [15:0] o_gain;
   logic [4:0]  o_sel_gain;
   logic        o_pending;

   eq_gain_scheduler #(.GAIN_MAX(12), .GAIN_MIN(-12), .FRAC_BITS(8)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_band_sel     (band_sel),
      .i_up           (up),
      .i_down         (down),
      .i_preset_load  (pload),
      .i_preset_id    (pid),
      .i_sample_start (start),
      .i_dsp_done     (done),
      .o_set_gain     (o_set_gain),
      .o_gain         (o_gain),
      .o_sel_gain     (o_sel_gain),
      .o_pending      (o_pending)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: gains in dB, dirty flags, DSP busy flag.
   int          mgain [1:6];
   bit          mdirty [1:6];
   bit          mbusy;
   logic [2:0]  exp_set;
   logic [15:0] exp_gain;
   logic        exp_pend;
   int          ptab [4][6] = '{'{0, 0, 0, 0, 0, 0},
                                '{6, 4, 2, 0, 0, 0},
                                '{0, 0, 0, 2, 4, 6},
                                '{6, 3, 0, 0, 3, 6}};
   int          wr_count;
   logic [15:0] last_gain;

   typedef struct {
      logic [2:0]  band;
      logic        up;
      logic [2:0]  exp_set;
      logic [15:0] exp_gain;
      logic        exp_pend;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(input logic [2:0] b, input logic u, input logic [2:0] es,
                               input logic [15:0] eg, input logic ep);
      vec_t v;
      v.band = b; v.up = u; v.exp_set = es; v.exp_gain = eg; v.exp_pend = ep;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 1; b <= 6; b++) begin
         mgain[b]  = 0;
         mdirty[b] = 1'b1;
      end
      mbusy    = 1'b0;
      exp_set  = 3'd0;
      exp_gain = 16'd0;
      exp_pend = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      bit wok;
      int b, nv;
      if (rst) begin
         model_reset();
         return;
      end
      wok      = !mbusy && !start;
      exp_set  = 3'd0;
      exp_gain = 16'd0;
      if (wok) begin
         for (int k = 1; k <= 6; k++) begin
            if (mdirty[k]) begin
               exp_set   = 3'(k);
               exp_gain  = 16'(mgain[k] * 256);
               mdirty[k] = 1'b0;
               break;
            end
         end
      end
      b = int'(band_sel);
      if (pload) begin
         for (int k = 1; k <= 6; k++) begin
            mgain[k]  = ptab[pid][k-1];
            mdirty[k] = 1'b1;
         end
      end else if (b >= 1 && b <= 6 && (up != down)) begin
         nv = mgain[b] + (up ? 1 : -1);
         if (nv >= -12 && nv <= 12) begin
            mgain[b]  = nv;
            mdirty[b] = 1'b1;
         end
      end
      if (start)     mbusy = 1'b1;
      else if (done) mbusy = 1'b0;
      exp_pend = 1'b0;
      for (int k = 1; k <= 6; k++) if (mdirty[k]) exp_pend = 1'b1;
   endtask

   function automatic logic [4:0] exp_sel();
      int b;
      b = int'(band_sel);
      if (b >= 1 && b <= 6) return 5'(mgain[b]);
      return 5'd0;
   endfunction

   // One clock: model, edge, compare everything, then drop the pulse inputs.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("set_gain", 16'(o_set_gain), 16'(exp_set));
      chk("gain",     o_gain,          exp_gain);
      chk("pending",  16'(o_pending),  16'(exp_pend));
      chk("sel_gain", 16'(o_sel_gain), 16'(exp_sel()));
      if (o_set_gain != 3'd0) begin
         wr_count++;
         last_gain = o_gain;
      end
      up = 1'b0; down = 1'b0; pload = 1'b0; start = 1'b0; done = 1'b0;
   endtask

   initial begin
      logic [15:0] exp5 [6];
      exp5 = '{16'h0600, 16'h0300, 16'h0000, 16'h0000, 16'h0300, 16'h0600};

      // Release-from-reset full resync, then three spaced steps on band 2.
      vecs[0]  = mk(3'd0, 1'b0, 3'd1, 16'h0000, 1'b1);
      vecs[1]  = mk(3'd0, 1'b0, 3'd2, 16'h0000, 1'b1);
      vecs[2]  = mk(3'd0, 1'b0, 3'd3, 16'h0000, 1'b1);
      vecs[3]  = mk(3'd0, 1'b0, 3'd4, 16'h0000, 1'b1);
      vecs[4]  = mk(3'd0, 1'b0, 3'd5, 16'h0000, 1'b1);
      vecs[5]  = mk(3'd0, 1'b0, 3'd6, 16'h0000, 1'b0);
      vecs[6]  = mk(3'd0, 1'b0, 3'd0, 16'h0000, 1'b0);
      vecs[7]  = mk(3'd2, 1'b1, 3'd0, 16'h0000, 1'b1);
      vecs[8]  = mk(3'd2, 1'b0, 3'd2, 16'h0100, 1'b0);
      vecs[9]  = mk(3'd2, 1'b0, 3'd0, 16'h0000, 1'b0);
      vecs[10] = mk(3'd2, 1'b0, 3'd0, 16'h0000, 1'b0);
      vecs[11] = mk(3'd2, 1'b1, 3'd0, 16'h0000, 1'b1);
      vecs[12] = mk(3'd2, 1'b0, 3'd2, 16'h0200, 1'b0);
      vecs[13] = mk(3'd2, 1'b0, 3'd0, 16'h0000, 1'b0);
      vecs[14] = mk(3'd2, 1'b0, 3'd0, 16'h0000, 1'b0);
      vecs[15] = mk(3'd2, 1'b1, 3'd0, 16'h0000, 1'b1);
      vecs[16] = mk(3'd2, 1'b0, 3'd2, 16'h0300, 1'b0);
      vecs[17] = mk(3'd2, 1'b0, 3'd0, 16'h0000, 1'b0);

      rst = 1'b1; band_sel = 3'd0; up = 1'b0; down = 1'b0; pload = 1'b0;
      pid = 2'd0; start = 1'b0; done = 1'b0;
      wr_count = 0; last_gain = 16'd0;
      model_reset();
      #2;
      chk("rst_set_gain", 16'(o_set_gain), 16'd0);
      chk("rst_gain",     o_gain,          16'd0);
      chk("rst_pending",  16'(o_pending),  16'd0);
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         band_sel = vecs[i].band;
         up       = vecs[i].up;
         tick();
         chk($sformatf("vec%0d_set", i),  16'(o_set_gain), 16'(vecs[i].exp_set));
         chk($sformatf("vec%0d_gain", i), o_gain,          vecs[i].exp_gain);
         chk($sformatf("vec%0d_pend", i), 16'(o_pending),  16'(vecs[i].exp_pend));
      end

      // Saturation on band 1: 13 ups then 25 downs.
      band_sel = 3'd1;
      wr_count = 0;
      for (int k = 0; k < 13; k++) begin
         up = 1'b1; tick(); tick(); tick();
      end
      chk("sat_up_writes", 16'(wr_count), 16'd12);
      chk("sat_up_gain",   last_gain,     16'h0C00);
      wr_count = 0;
      for (int k = 0; k < 25; k++) begin
         down = 1'b1; tick(); tick(); tick();
      end
      chk("sat_dn_writes", 16'(wr_count), 16'd24);
      chk("sat_dn_gain",   last_gain,     16'hF400);
      chk("sat_sel",       16'(o_sel_gain), 16'h0014);

      // Writes held off while the DSP is processing a sample.
      band_sel = 3'd4;
      start = 1'b1; tick();
      up = 1'b1; tick();
      wr_count = 0;
      repeat (5) tick();
      chk("busy_hold_writes", 16'(wr_count), 16'd0);
      done = 1'b1; tick();
      chk("done_cycle_set", 16'(o_set_gain), 16'd0);
      tick();
      chk("after_done_set",  16'(o_set_gain), 16'd4);
      chk("after_done_gain", o_gain,          16'h0100);
      tick();
      chk("after_done_idle", 16'(o_set_gain), 16'd0);

      // Preset beats a simultaneous step.
      band_sel = 3'd3;
      pload = 1'b1; pid = 2'd3; up = 1'b1; tick();
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("loud_set%0d", k),  16'(o_set_gain), 16'(k));
         chk($sformatf("loud_gain%0d", k), o_gain,          exp5[k-1]);
      end
      tick();
      chk("loud_done_set", 16'(o_set_gain), 16'd0);
      chk("loud_band3",    16'(o_sel_gain), 16'd0);

      // Reset in the middle of a preset write burst.
      pload = 1'b1; pid = 2'd1; tick();
      tick(); tick(); tick();
      chk("bass_set3",  16'(o_set_gain), 16'd3);
      chk("bass_gain3", o_gain,          16'h0200);
      rst = 1'b1;
      #1;
      chk("rst_abort_set",  16'(o_set_gain), 16'd0);
      chk("rst_abort_gain", o_gain,          16'd0);
      model_reset();
      tick(); tick();
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("resync_set%0d", k),  16'(o_set_gain), 16'(k));
         chk($sformatf("resync_gain%0d", k), o_gain,          16'd0);
      end
      tick();
      chk("resync_pending", 16'(o_pending), 16'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         band_sel = 3'($urandom_range(0, 7));
         up       = ($urandom_range(0, 5) == 0);
         down     = ($urandom_range(0, 5) == 0);
         pload    = ($urandom_range(0, 63) == 0);
         pid      = 2'($urandom_range(0, 3));
         start    = ($urandom_range(0, 9) == 0);
         done     = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 499) == 0) rst = 1'b1;
         tick();
         rst = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
